// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard, branch-flush and SRAM-wait stall controller
// with a sticky timeout error state and a saturating stall-cycle counter.
module stall_ctrl #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [4:0]       src1_ID,
  input  logic [4:0]       src2_ID,
  input  logic             two_src_ID,
  input  logic [4:0]       dest_EXE,
  input  logic             wb_en_EXE,
  input  logic             mem_read_EXE,
  input  logic [4:0]       dest_MEM,
  input  logic             wb_en_MEM,
  input  logic             mem_req_MEM,
  input  logic             branch_taken,
  input  logic             sram_ready,
  output logic             sram_req,
  output logic             freeze_IF,
  output logic             freeze_ID,
  output logic             bubble,
  output logic             stall_all,
  output logic             flush,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hit_exe, w_hit_mem, w_hazard;
  assign w_hit_exe = (dest_EXE == src1_ID) | (two_src_ID & (dest_EXE == src2_ID));
  assign w_hit_mem = (dest_MEM == src1_ID) | (two_src_ID & (dest_MEM == src2_ID));
  assign w_hazard  = forward_en ? (wb_en_EXE & mem_read_EXE & w_hit_exe)
                                : ((wb_en_EXE & w_hit_exe) | (wb_en_MEM & w_hit_mem));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_wait_cnt  <= (r_state == RUN) ? 8'd0 :
                     (r_state == WAIT && !sram_ready) ? r_wait_cnt + 8'd1 : r_wait_cnt;
      r_stall_cnt <= (freeze_IF && !(&r_stall_cnt)) ? r_stall_cnt + 1'b1 : r_stall_cnt;
    end
  end
  // sram_ready is deliberately ignored in RUN so every access spends at least one WAIT cycle
  always_comb begin
    w_next = (r_state == RUN)  ? (mem_req_MEM ? WAIT : RUN) :
             (r_state == WAIT) ? (sram_ready ? RUN :
                                  (r_wait_cnt == 8'(TIMEOUT - 1)) ? ERR : WAIT) : ERR;
  end
  always_comb begin
    sram_req  = (r_state == RUN) ? mem_req_MEM : (r_state == WAIT);
    stall_all = (r_state == RUN) ? mem_req_MEM : (r_state == WAIT) ? !sram_ready : 1'b1;
    freeze_IF = stall_all | (!branch_taken & w_hazard);
    freeze_ID = freeze_IF;
    bubble    = !stall_all & !branch_taken & w_hazard;
    flush     = !stall_all & branch_taken;
    err       = (r_state == ERR);
  end
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: scoreboard bench; expected output vectors and stall counts are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_stall_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  // {sram_req, freeze_IF, freeze_ID, bubble, stall_all, flush, err}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_HAZ  = 7'b0111000;
  localparam logic [6:0] O_MEM  = 7'b1110100;
  localparam logic [6:0] O_RDY  = 7'b1000000;
  localparam logic [6:0] O_ERR  = 7'b0110101;
  localparam logic [6:0] O_FL   = 7'b0000010;
  localparam logic [6:0] O_RFL  = 7'b1000010;

  logic clk = 1'b0, rst = 1'b0;
  logic forward_en, two_src_ID, wb_en_EXE, mem_read_EXE, wb_en_MEM, mem_req_MEM, branch_taken, sram_ready;
  logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic sram_req, freeze_IF, freeze_ID, bubble, stall_all, flush, err;
  logic [CW-1:0] stall_cnt;
  logic [6:0] outs;

  typedef struct packed {logic [6:0] o; logic [CW-1:0] c;} exp_t;
  typedef struct {
    logic fwd; logic [4:0] s1, s2; logic two; logic [4:0] de; logic wee, mre;
    logic [4:0] dm; logic wem, br; logic [6:0] o;
  } hz_t;

  exp_t exp_q[$];
  logic [CW-1:0] exp_cnt;
  int errors = 0, checks = 0;

  stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .src1_ID(src1_ID), .src2_ID(src2_ID),
    .two_src_ID(two_src_ID), .dest_EXE(dest_EXE), .wb_en_EXE(wb_en_EXE),
    .mem_read_EXE(mem_read_EXE), .dest_MEM(dest_MEM), .wb_en_MEM(wb_en_MEM),
    .mem_req_MEM(mem_req_MEM), .branch_taken(branch_taken), .sram_ready(sram_ready),
    .sram_req(sram_req), .freeze_IF(freeze_IF), .freeze_ID(freeze_ID), .bubble(bubble),
    .stall_all(stall_all), .flush(flush), .err(err), .stall_cnt(stall_cnt)
  );

  assign outs = {sram_req, freeze_IF, freeze_ID, bubble, stall_all, flush, err};
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c, input logic [6:0] o);
    return (o[5] && c != {CW{1'b1}}) ? c + 1'b1 : c;
  endfunction

  task automatic idle();
    forward_en = 0; two_src_ID = 0; wb_en_EXE = 0; mem_read_EXE = 0; wb_en_MEM = 0;
    mem_req_MEM = 0; branch_taken = 0; sram_ready = 0;
    src1_ID = 0; src2_ID = 0; dest_EXE = 0; dest_MEM = 0;
  endtask

  task automatic apply(input hz_t t);
    forward_en = t.fwd; src1_ID = t.s1; src2_ID = t.s2; two_src_ID = t.two;
    dest_EXE = t.de; wb_en_EXE = t.wee; mem_read_EXE = t.mre;
    dest_MEM = t.dm; wb_en_MEM = t.wem; branch_taken = t.br;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    mem_req_MEM = 1;
    exp_q.push_back({O_MEM, exp_cnt});
    @(negedge clk); e = exp_q.pop_front(); checks += 2;
    if (outs !== e.o) begin errors++; $display("FAIL reset_run outs got=%b exp=%b", outs, e.o); end
    if (stall_cnt !== e.c) begin errors++; $display("FAIL reset_run cnt got=%0d exp=%0d", stall_cnt, e.c); end
    @(posedge clk); #1; exp_cnt = next_cnt(exp_cnt, e.o);
    mem_req_MEM = 0;
    exp_q.push_back({O_MEM, exp_cnt});
    @(negedge clk); e = exp_q.pop_front(); checks += 2;
    if (outs !== e.o) begin errors++; $display("FAIL reset_wait outs got=%b exp=%b", outs, e.o); end
    if (stall_cnt !== e.c) begin errors++; $display("FAIL reset_wait cnt got=%0d exp=%0d", stall_cnt, e.c); end
    #1 rst = 1'b0; exp_cnt = '0;
    exp_q.push_back({O_IDLE, exp_cnt});
    #1 e = exp_q.pop_front(); checks += 2;
    if (outs !== e.o) begin errors++; $display("FAIL reset_abort outs got=%b exp=%b", outs, e.o); end
    if (stall_cnt !== e.c) begin errors++; $display("FAIL reset_abort cnt got=%0d exp=%0d", stall_cnt, e.c); end
    mem_req_MEM = 1;
    exp_q.push_back({O_MEM, exp_cnt});
    #1 e = exp_q.pop_front(); checks++;
    if (outs !== e.o) begin errors++; $display("FAIL reset_follow outs got=%b exp=%b", outs, e.o); end
    repeat (2) @(posedge clk);
    mem_req_MEM = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({O_IDLE, exp_cnt});
    @(negedge clk); e = exp_q.pop_front(); checks += 2;
    if (outs !== e.o) begin errors++; $display("FAIL reset_release outs got=%b exp=%b", outs, e.o); end
    if (stall_cnt !== e.c) begin errors++; $display("FAIL reset_release cnt got=%0d exp=%0d", stall_cnt, e.c); end
  endtask

  task automatic test_load_use();
    hz_t t[8];
    exp_t e;
    t[0] = '{1'b1, 5'd3, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_HAZ};
    t[1] = '{1'b1, 5'd3, 5'd7, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_IDLE};
    t[2] = '{1'b1, 5'd0, 5'd7, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, O_HAZ};
    t[3] = '{1'b1, 5'd3, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, O_IDLE};
    t[4] = '{1'b1, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_HAZ};
    t[5] = '{1'b1, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_IDLE};
    t[6] = '{1'b1, 5'd3, 5'd7, 1'b0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, O_IDLE};
    t[7] = '{1'b1, 5'd3, 5'd7, 1'b0, 5'd19, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_IDLE};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(t[i]);
      exp_q.push_back({t[i].o, exp_cnt});
      @(negedge clk); e = exp_q.pop_front(); checks += 2;
      if (outs !== e.o) begin errors++; $display("FAIL load_use[%0d] outs got=%b exp=%b", i, outs, e.o); end
      if (stall_cnt !== e.c) begin errors++; $display("FAIL load_use[%0d] cnt got=%0d exp=%0d", i, stall_cnt, e.c); end
      @(posedge clk); #1; exp_cnt = next_cnt(exp_cnt, e.o);
    end
  endtask

  task automatic test_no_fwd();
    hz_t t[6];
    exp_t e;
    t[0] = '{1'b0, 5'd1, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, O_HAZ};
    t[1] = '{1'b0, 5'd1, 5'd5, 1'b0, 5'd9, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, O_IDLE};
    t[2] = '{1'b0, 5'd1, 5'd2, 1'b0, 5'd1, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, O_HAZ};
    t[3] = '{1'b0, 5'd1, 5'd2, 1'b0, 5'd1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, O_IDLE};
    t[4] = '{1'b0, 5'd0, 5'd2, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, O_HAZ};
    t[5] = '{1'b0, 5'd1, 5'd5, 1'b1, 5'd9, 1'b0, 1'b0, 5'd21, 1'b1, 1'b0, O_IDLE};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(t[i]);
      exp_q.push_back({t[i].o, exp_cnt});
      @(negedge clk); e = exp_q.pop_front(); checks += 2;
      if (outs !== e.o) begin errors++; $display("FAIL no_fwd[%0d] outs got=%b exp=%b", i, outs, e.o); end
      if (stall_cnt !== e.c) begin errors++; $display("FAIL no_fwd[%0d] cnt got=%0d exp=%0d", i, stall_cnt, e.c); end
      @(posedge clk); #1; exp_cnt = next_cnt(exp_cnt, e.o);
    end
  endtask

  task automatic test_sram();
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mem_req_MEM = (i < 5);
      sram_ready  = (i == 0 || i == 4);
      exp_q.push_back({(i < 4) ? O_MEM : (i == 4) ? O_RDY : O_IDLE, exp_cnt});
      @(negedge clk); e = exp_q.pop_front(); checks += 2;
      if (outs !== e.o) begin errors++; $display("FAIL sram[%0d] outs got=%b exp=%b", i, outs, e.o); end
      if (stall_cnt !== e.c) begin errors++; $display("FAIL sram[%0d] cnt got=%0d exp=%0d", i, stall_cnt, e.c); end
      @(posedge clk); #1; exp_cnt = next_cnt(exp_cnt, e.o);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    do_reset();
    apply('{1'b1, 5'd3, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, O_FL});
    for (int i = 0; i < 5; i++) begin
      mem_req_MEM  = (i == 1 || i == 2 || i == 3);
      sram_ready   = (i == 3);
      branch_taken = (i < 4);
      exp_q.push_back({(i == 0) ? O_FL : (i == 3) ? O_RFL : (i == 4) ? O_HAZ : O_MEM, exp_cnt});
      @(negedge clk); e = exp_q.pop_front(); checks += 2;
      if (outs !== e.o) begin errors++; $display("FAIL priority[%0d] outs got=%b exp=%b", i, outs, e.o); end
      if (stall_cnt !== e.c) begin errors++; $display("FAIL priority[%0d] cnt got=%0d exp=%0d", i, stall_cnt, e.c); end
      @(posedge clk); #1; exp_cnt = next_cnt(exp_cnt, e.o);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_req_MEM = 1;
      sram_ready  = (i == 7);
      exp_q.push_back({(i < 5) ? O_MEM : O_ERR, exp_cnt});
      @(negedge clk); e = exp_q.pop_front(); checks += 2;
      if (outs !== e.o) begin errors++; $display("FAIL timeout[%0d] outs got=%b exp=%b", i, outs, e.o); end
      if (stall_cnt !== e.c) begin errors++; $display("FAIL timeout[%0d] cnt got=%0d exp=%0d", i, stall_cnt, e.c); end
      @(posedge clk); #1; exp_cnt = next_cnt(exp_cnt, e.o);
    end
    rst = 1'b0; exp_cnt = '0;
    exp_q.push_back({O_MEM, exp_cnt});
    #1 e = exp_q.pop_front(); checks += 2;
    if (outs !== e.o) begin errors++; $display("FAIL timeout_rst outs got=%b exp=%b", outs, e.o); end
    if (stall_cnt !== e.c) begin errors++; $display("FAIL timeout_rst cnt got=%0d exp=%0d", stall_cnt, e.c); end
    mem_req_MEM = 0;
    exp_q.push_back({O_IDLE, exp_cnt});
    #1 e = exp_q.pop_front(); checks++;
    if (outs !== e.o) begin errors++; $display("FAIL timeout_rst_idle outs got=%b exp=%b", outs, e.o); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    apply('{1'b1, 5'd3, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, O_HAZ});
    for (int i = 0; i < 22; i++) begin
      exp_q.push_back({O_HAZ, exp_cnt});
      @(negedge clk); e = exp_q.pop_front(); checks += 2;
      if (outs !== e.o) begin errors++; $display("FAIL sat[%0d] outs got=%b exp=%b", i, outs, e.o); end
      if (stall_cnt !== e.c) begin errors++; $display("FAIL sat[%0d] cnt got=%0d exp=%0d", i, stall_cnt, e.c); end
      @(posedge clk); #1; exp_cnt = next_cnt(exp_cnt, e.o);
    end
    idle();
    exp_q.push_back({O_IDLE, 4'd15});
    @(negedge clk); e = exp_q.pop_front(); checks++;
    if (stall_cnt !== e.c) begin errors++; $display("FAIL sat_hold cnt got=%0d exp=%0d", stall_cnt, e.c); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_fwd();
    test_sram();
    test_priority();
    test_timeout();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
